// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//
// Load/store stage of the fewcore pipeline. It sits between the execute result
// latch and register write-back. It accepts one executed instruction per
// in_valid/in_ready handshake and issues at most one data-memory request for
// it on a req/ack bus. It formats store byte lanes and sign/zero-extends load
// data, then emits a one-cycle result pulse to write-back.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   execute handshake (in_ready is high only in IDLE)
//   in_rd, in_alu       destination register, ALU result / effective address
//   in_store_data       rs2 value for stores
//   in_op               funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   in_is_load/store    access type
//   mem_req/mem_ack     memory handshake; mem_req is held until ack or timeout
//   mem_we, mem_addr    write flag, word-aligned address
//   mem_wdata, mem_be   lane-replicated store data, byte enables
//   mem_rdata           read word, valid together with mem_ack
//   out_valid           one-cycle result pulse
//   out_rd, out_data    destination register, write-back value
//   out_wen             register write enable, only ever high with out_valid
//   out_err             00 ok, 01 misaligned, 10 timeout, 11 illegal
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_store_data,
  input  logic [2:0]  in_op,
  input  logic        in_is_load,
  input  logic        in_is_store,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic        out_wen,
  output logic [1:0]  out_err
);

  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic { IDLE, ACCESS } state_t;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_TIMEOUT    = 2'b10,
    ERR_ILLEGAL    = 2'b11
  } err_t;

  // Register state (_q) and next values (_d)
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_wen_q, out_wen_d;
  err_t              out_err_q, out_err_d;

  // Context of the outstanding access, needed once the ack arrives
  logic [4:0]        acc_rd_q, acc_rd_d;
  logic [2:0]        acc_op_q, acc_op_d;
  logic [1:0]        acc_lo_q, acc_lo_d;
  logic              acc_load_q, acc_load_d;

  // Decode of the incoming instruction
  logic              is_mem;
  logic              illegal;
  logic              misaligned;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;

  assign is_mem = in_is_load | in_is_store;

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    st_be      = 4'b0000;
    st_wdata   = 32'h0;

    if (in_is_load && in_is_store) begin
      illegal = 1'b1;
    end else if (in_is_store) begin
      illegal = !(in_op inside {3'b000, 3'b001, 3'b010});
    end else if (in_is_load) begin
      illegal = in_op inside {3'b011, 3'b110, 3'b111};
    end

    // Halfword ops (H/HU share op[1:0]=01) need addr[0]=0; words need 4-byte
    // alignment. Only meaningful for legal memory ops.
    if ((in_op[1:0] == 2'b01) && in_alu[0]) begin
      misaligned = 1'b1;
    end else if ((in_op == 3'b010) && (in_alu[1:0] != 2'b00)) begin
      misaligned = 1'b1;
    end

    case (in_op[1:0])
      2'b00: begin
        st_be    = 4'b0001 << in_alu[1:0];
        st_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        st_be    = in_alu[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{in_store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_store_data;
      end
    endcase
  end

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (op)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    out_valid_d = 1'b0;          // result is a single-cycle pulse
    out_wen_d   = 1'b0;          // never asserted without out_valid
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    acc_rd_d    = acc_rd_q;
    acc_op_d    = acc_op_q;
    acc_lo_d    = acc_lo_q;
    acc_load_d  = acc_load_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_rd_d = in_rd;
          if (!is_mem) begin
            out_valid_d = 1'b1;
            out_data_d  = in_alu;
            out_wen_d   = (in_rd != 5'd0);
            out_err_d   = ERR_OK;
          end else if (illegal) begin
            out_valid_d = 1'b1;
            out_data_d  = in_alu;
            out_err_d   = ERR_ILLEGAL;
          end else if (misaligned) begin
            out_valid_d = 1'b1;
            out_data_d  = in_alu;
            out_err_d   = ERR_MISALIGNED;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = in_is_store;
            mem_addr_d  = {in_alu[31:2], 2'b00};
            mem_be_d    = in_is_store ? st_be : 4'b0000;
            mem_wdata_d = in_is_store ? st_wdata : 32'h0;
            acc_rd_d    = in_rd;
            acc_op_d    = in_op;
            acc_lo_d    = in_alu[1:0];
            acc_load_d  = in_is_load;
          end
        end
      end

      ACCESS: begin
        if (mem_ack) begin
          // An ack in the last allowed cycle still completes the access.
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          out_rd_d    = acc_rd_q;
          out_err_d   = ERR_OK;
          if (acc_load_q) begin
            out_data_d = load_extend(acc_op_q, acc_lo_q, mem_rdata);
            out_wen_d  = (acc_rd_q != 5'd0);
          end else begin
            out_data_d = {mem_addr_q[31:2], acc_lo_q};
          end
        end else if (cnt_q == CNT_LAST) begin
          // This edge is where the count would reach WAIT_MAX: give up.
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          out_valid_d = 1'b1;
          out_rd_d    = acc_rd_q;
          out_data_d  = {mem_addr_q[31:2], acc_lo_q};
          out_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      out_valid_q <= 1'b0;
      out_rd_q    <= 5'd0;
      out_data_q  <= 32'h0;
      out_wen_q   <= 1'b0;
      out_err_q   <= ERR_OK;
      acc_rd_q    <= 5'd0;
      acc_op_q    <= 3'b000;
      acc_lo_q    <= 2'b00;
      acc_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      out_wen_q   <= out_wen_d;
      out_err_q   <= out_err_d;
      acc_rd_q    <= acc_rd_d;
      acc_op_q    <= acc_op_d;
      acc_lo_q    <= acc_lo_d;
      acc_load_q  <= acc_load_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign out_data  = out_data_q;
  assign out_wen   = out_wen_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//
// Directed bench for memory_access (WAIT_MAX = 4). Inputs are driven and
// outputs sampled on the falling clock edge; the memory side (ack/rdata) is
// driven by hand in each step with hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_store_data;
  logic [2:0]  in_op;
  logic        in_is_load;
  logic        in_is_store;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        out_wen;
  logic [1:0]  out_err;

  int checks = 0;
  int errors = 0;

  memory_access #(.WAIT_MAX(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_alu        (in_alu),
    .in_store_data (in_store_data),
    .in_op         (in_op),
    .in_is_load    (in_is_load),
    .in_is_store   (in_is_store),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .out_valid     (out_valid),
    .out_rd        (out_rd),
    .out_data      (out_data),
    .out_wen       (out_wen),
    .out_err       (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [2:0] op,
                       input logic ld, input logic st);
    in_valid      = 1'b1;
    in_rd         = rd;
    in_alu        = alu;
    in_store_data = sd;
    in_op         = op;
    in_is_load    = ld;
    in_is_store   = st;
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_in();
    in_rd = 5'd0; in_alu = 32'h0; in_store_data = 32'h0; in_op = 3'b000;
    mem_ack = 1'b0; mem_rdata = 32'h0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    reset = 1'b1;
    tick();

    // ---------------- pass-through, back to back ----------------
    issue(5'd5, 32'h12, 32'h0, 3'b000, 0, 0);
    tick();
    check("pt0_valid", out_valid, 1);
    check("pt0_data", out_data, 32'h12);
    check("pt0_wen", out_wen, 1);
    check("pt0_rd", out_rd, 5);
    check("pt0_ready", in_ready, 1);
    issue(5'd0, 32'h7, 32'h0, 3'b000, 0, 0);
    tick();
    check("pt1_valid", out_valid, 1);
    check("pt1_data", out_data, 32'h7);
    check("pt1_wen", out_wen, 0);
    check("pt1_ready", in_ready, 1);
    issue(5'd9, 32'hFFFF_FFFF, 32'h0, 3'b000, 0, 0);
    tick();
    check("pt2_valid", out_valid, 1);
    check("pt2_data", out_data, 32'hFFFF_FFFF);
    check("pt2_wen", out_wen, 1);
    check("pt2_ready", in_ready, 1);
    idle_in();
    tick();
    check("pt_idle_valid", out_valid, 0);
    check("pt_idle_wen", out_wen, 0);
    check("pt_hold_data", out_data, 32'hFFFF_FFFF);
    check("pt_hold_rd", out_rd, 9);

    // ---------------- LB 0x1003, ack after 2 waits ----------------
    issue(5'd3, 32'h1003, 32'h0, 3'b000, 1, 0);
    tick();                                   // cycle N+1
    idle_in();
    check("lb_req", mem_req, 1);
    check("lb_addr", mem_addr, 32'h1000);
    check("lb_we", mem_we, 0);
    check("lb_be", mem_be, 4'b0000);
    check("lb_ready_low", in_ready, 0);
    tick();                                   // cycle N+2
    check("lb_req_wait", mem_req, 1);
    check("lb_valid_wait", out_valid, 0);
    tick();                                   // cycle N+3: ack
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    check("lb_ready_ack_cycle", in_ready, 0);
    tick();                                   // cycle N+4
    mem_ack = 1'b0;
    check("lb_valid", out_valid, 1);
    check("lb_data", out_data, 32'hFFFF_FF80);
    check("lb_wen", out_wen, 1);
    check("lb_rd", out_rd, 3);
    check("lb_err", out_err, 0);
    check("lb_req_done", mem_req, 0);
    check("lb_ready_back", in_ready, 1);

    // ---------------- LBU same address, zero wait ----------------
    issue(5'd3, 32'h1003, 32'h0, 3'b100, 1, 0);
    tick();
    idle_in();
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    check("lbu_req", mem_req, 1);
    tick();
    mem_ack = 1'b0;
    check("lbu_valid", out_valid, 1);
    check("lbu_data", out_data, 32'h0000_0080);

    // ---------------- SB 0x22 ----------------
    issue(5'd7, 32'h22, 32'hAABB_CCDD, 3'b000, 0, 1);
    tick();
    idle_in();
    check("sb_be", mem_be, 4'b0100);
    check("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    check("sb_we", mem_we, 1);
    check("sb_addr", mem_addr, 32'h20);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sb_valid", out_valid, 1);
    check("sb_wen", out_wen, 0);
    check("sb_data", out_data, 32'h22);

    // ---------------- SH 0x22 ----------------
    issue(5'd7, 32'h22, 32'hAABB_CCDD, 3'b001, 0, 1);
    tick();
    idle_in();
    check("sh_be", mem_be, 4'b1100);
    check("sh_wdata", mem_wdata, 32'hCCDD_CCDD);
    check("sh_we", mem_we, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_valid", out_valid, 1);
    check("sh_wen", out_wen, 0);
    check("sh_err", out_err, 0);

    // ---------------- misaligned LW, illegal store ----------------
    issue(5'd4, 32'h102, 32'h0, 3'b010, 1, 0);
    tick();
    check("mis_req", mem_req, 0);
    check("mis_valid", out_valid, 1);
    check("mis_err", out_err, 2'b01);
    check("mis_wen", out_wen, 0);
    check("mis_ready", in_ready, 1);
    issue(5'd4, 32'h40, 32'h0, 3'b100, 0, 1);
    tick();
    idle_in();
    check("ill_req", mem_req, 0);
    check("ill_valid", out_valid, 1);
    check("ill_err", out_err, 2'b11);
    check("ill_wen", out_wen, 0);

    // ---------------- timeout: never ack ----------------
    issue(5'd6, 32'h200, 32'h0, 3'b010, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      idle_in();
      check($sformatf("to_req_c%0d", i + 1), mem_req, 1);
    end
    tick();
    check("to_req_drop", mem_req, 0);
    check("to_valid", out_valid, 1);
    check("to_err", out_err, 2'b10);
    check("to_wen", out_wen, 0);
    check("to_ready", in_ready, 1);

    // ---------------- ack on the 4th cycle wins ----------------
    issue(5'd6, 32'h200, 32'h0, 3'b010, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_in();
      check($sformatf("ack4_req_c%0d", i + 1), mem_req, 1);
    end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    check("ack4_req_c4", mem_req, 1);
    tick();
    mem_ack = 1'b0;
    check("ack4_valid", out_valid, 1);
    check("ack4_err", out_err, 2'b00);
    check("ack4_data", out_data, 32'h1234_5678);
    check("ack4_wen", out_wen, 1);

    // ---------------- reset mid-access ----------------
    issue(5'd2, 32'h300, 32'h0, 3'b010, 1, 0);
    tick();
    idle_in();
    check("rma_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    check("rma_req_cleared", mem_req, 0);
    check("rma_ready", in_ready, 1);
    check("rma_valid", out_valid, 0);
    check("rma_data_cleared", out_data, 0);
    tick();
    reset = 1'b1;
    tick();
    check("rma_no_result", out_valid, 0);
    check("rma_idle_req", mem_req, 0);

    // normal LW after release
    issue(5'd1, 32'h304, 32'h0, 3'b010, 1, 0);
    tick();
    idle_in();
    check("post_req", mem_req, 1);
    check("post_addr", mem_addr, 32'h304);
    check("post_be", mem_be, 4'b0000);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_BABE;
    tick();
    mem_ack = 1'b0;
    check("post_valid", out_valid, 1);
    check("post_data", out_data, 32'hCAFE_BABE);
    check("post_wen", out_wen, 1);
    check("post_rd", out_rd, 1);
    check("post_err", out_err, 0);
    tick();
    check("post_pulse_end", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Load/store stage between the execute-stage result latch and the register write-back stage of the fewcore pipeline. It takes one executed instruction per handshake and issues at most one data-memory request for it. The request uses a req/ack bus, with byte-lane formatting for stores and sign/zero extension for loads. It then hands a single-cycle result to write-back. While a memory access is outstanding it back-pressures execute, and it flags misaligned, illegal and timed-out accesses.

## Interface
- `WAIT_MAX`, default 15: cycles `mem_req` may stay high without `mem_ack` before the access is abandoned (≥1).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  execute result present.
- `in_ready`  out  1  stage can accept; equals (state == IDLE).
- `in_rd`  in  5  destination register.
- `in_alu`  in  32  ALU result; this is the effective address for load/store.
- `in_store_data`  in  32  rs2 value for stores.
- `in_op`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `in_is_load`, `in_is_store`  in  1 each  access type.
- `mem_req`  out  1  memory request, held until ack or timeout.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{in_alu[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables; 0000 for loads.
- `mem_ack`  in  1  request completed; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `out_valid`  out  1  one-cycle result pulse to write-back.
- `out_rd`  out  5  destination register.
- `out_data`  out  32  write-back value.
- `out_wen`  out  1  register write enable.
- `out_err`  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal.

## Operation
- FSM states: IDLE, ACCESS.
- **Accept:** in IDLE with `in_valid`=1 the instruction is accepted at the clock edge.
- **Pass-through** (neither load nor store):
  - Next cycle: `out_valid`=1, `out_data`=`in_alu`, `out_wen`=(`in_rd`≠0), `out_err`=00.
  - State stays IDLE.
- **Illegal:** `in_is_load` and `in_is_store` both 1, a store with `in_op` ∉ {000,001,010}, or a load with `in_op` ∈ {011,110,111}.
  - Next cycle: `out_valid`=1, `out_wen`=0, `out_err`=11.
  - No request is issued.
- **Misaligned:** H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Next cycle: `out_valid`=1, `out_wen`=0, `out_err`=01.
  - No request is issued.
- **Legal load/store:** the request registers are loaded and the FSM enters ACCESS with `mem_req`=1.
  - SB: `be` = 0001 << `addr[1:0]`, `wdata` = {4{`sd[7:0]`}}.
  - SH: `be` = `addr[1]` ? 1100 : 0011, `wdata` = {2{`sd[15:0]`}}.
  - SW: `be` = 1111, `wdata` = `sd`.
  - Loads: `mem_we`=0, `be`=0000.
- **ACCESS with `mem_ack`=1:** at the edge, `mem_req`←0, state←IDLE, and `out_valid`=1 next cycle.
  - Loads: lane selected by `addr[1:0]` (B/BU) or `addr[1]` (H/HU); sign-extended for B/H, zero-extended for BU/HU; `out_wen`=(rd≠0).
  - Stores: `out_wen`=0, `out_data`=address.
- **Timeout:** wait counter increments each ACCESS cycle with `mem_ack`=0.
  - At the edge where the counter reaches `WAIT_MAX`: `mem_req`←0, state←IDLE, and next cycle `out_valid`=1, `out_wen`=0, `out_err`=10.
  - `mem_ack` in that same cycle wins over timeout.
  - The counter clears on entering ACCESS.
- **Hold rules:**
  - `out_valid` is high exactly one cycle per accepted instruction.
  - `out_rd`/`out_data`/`out_err` hold their last values otherwise.
  - `out_wen` is 0 whenever `out_valid`=0.
- **Reset:** `reset`=0 at any time, including mid-ACCESS, forces IDLE immediately.
  - Every output register clears: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, `out_valid`, `out_rd`, `out_data`, `out_wen`, `out_err`, and the counter.
  - A pending access is dropped without a result.
  - `in_ready` is 1 during reset.

## Timing
- Pass-through, illegal and misaligned: accept edge N, `out_valid` in cycle N+1, 1/clk throughput with `in_ready` continuously high.
- Load/store: accept edge N, `mem_req` high from cycle N+1; with ack in cycle N+1+k, `out_valid` in cycle N+2+k.
- `in_ready` is low from cycle N+1 through the ack cycle and high again in N+2+k.
  - Zero-wait access: 2-cycle latency, one new memory op every 2 cycles.
- Memory outputs are stable while `mem_req`=1.
- All outputs are registered except `in_ready`.

## Test plan
- **Pass-through:** 3 back-to-back ALU ops (rd=5, alu=0x12; rd=0, alu=7; rd=9, alu=0xFFFF_FFFF) -> `out_valid` on 3 consecutive cycles, `out_wen`=1,0,1, `in_ready` never drops.
- **LB sign-extend:** LB at 0x1003, `mem_rdata`=0x80FF_0000, ack after 2 waits -> `mem_addr`=0x1000, `out_data`=0xFFFF_FF80, `out_valid` 4 cycles after accept; LBU at the same address -> 0x0000_0080.
- **SB/SH formatting:** SB at 0x22, sd=0xAABBCCDD -> `be`=0100, `wdata`=0xDDDDDDDD, `we`=1; SH at 0x22 -> `be`=1100, `wdata`=0xCCDDCCDD, `out_wen`=0.
- **Misaligned and illegal:** LW at 0x102 -> no `mem_req`, `out_err`=01 next cycle; store with `in_op`=100 -> `out_err`=11.
- **Timeout:** `WAIT_MAX`=4, never ack -> `mem_req` high exactly 4 cycles, then `out_err`=10, `out_wen`=0; repeat with ack on the 4th cycle -> `out_err`=00.
- **Reset mid-access:** pull `reset` low during ACCESS -> `mem_req`=0 and `in_ready`=1 immediately, no `out_valid`; after release a normal LW completes.
